// File: rtl/cpu_branch_pkg.sv
// Shared types for the branch resolution stage: branch kinds, condition codes
// and the redirect/flush FSM state encoding.
package cpu_branch_pkg;

  localparam int unsigned STAT_W = 16;

  typedef enum logic [1:0] {
    BR_UNCOND = 2'b00,
    BR_COND   = 2'b01,
    BR_CBZ    = 2'b10,
    BR_CBNZ   = 2'b11
  } br_type_t;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_HS = 4'h2;
  localparam logic [3:0] COND_LO = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_REDIRECT = 2'b01,
    S_FLUSH    = 2'b10
  } state_t;

endpackage

// File: rtl/cond_eval.sv
// Condition-code evaluator: maps a 4-bit condition and NZVC flags to taken.
// Ports: cond (condition code), n/z/v/c (flags), taken_c (combinational result).
module cond_eval
  import cpu_branch_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       n,
  input  logic       z,
  input  logic       v,
  input  logic       c,
  output logic       taken_c
);

  always_comb begin
    taken_c = 1'b0;
    case (cond)
      COND_EQ: taken_c = z;
      COND_NE: taken_c = !z;
      COND_HS: taken_c = c;
      COND_LO: taken_c = !c;
      COND_MI: taken_c = n;
      COND_PL: taken_c = !n;
      COND_VS: taken_c = v;
      COND_VC: taken_c = !v;
      COND_HI: taken_c = c && !z;
      COND_LS: taken_c = !c || z;
      COND_GE: taken_c = (n == v);
      COND_LT: taken_c = (n != v);
      COND_GT: taken_c = !z && (n == v);
      COND_LE: taken_c = z || (n != v);
      COND_AL: taken_c = 1'b1;
      COND_NV: taken_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_branch_unit.sv
// Branch resolution stage: resolves B / B.cond / CBZ / CBNZ using forwarded
// or architectural NZVC flags, issues a one-cycle registered PC redirect and
// holds flush for FLUSH_DEPTH cycles to kill wrong-path instructions.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   br_valid, br_type, cond           branch in decode, kind, condition code
//   br_target                         computed branch target
//   reg_is_zero                       tested register is zero (CBZ/CBNZ)
//   ex_set_flags, alu_*               same-cycle flags from a flag-setting op in EX
//   curr_*                            architectural flags
//   redirect, redirect_pc             redirect strobe and target (pc holds)
//   flush, busy                       kill younger stages / FSM active
// Optional feature macro BRANCH_STATS_EN adds saturating taken_count and
// nottaken_count outputs.
module cond_branch_unit
  import cpu_branch_pkg::*;
#(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              br_valid,
  input  logic [1:0]        br_type,
  input  logic [3:0]        cond,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              reg_is_zero,
  input  logic              ex_set_flags,
  input  logic              alu_negative,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  input  logic              alu_carryout,
  input  logic              curr_negative,
  input  logic              curr_zero,
  input  logic              curr_overflow,
  input  logic              curr_carryout,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic              busy
`ifdef BRANCH_STATS_EN
  ,
  output logic [STAT_W-1:0] taken_count,
  output logic [STAT_W-1:0] nottaken_count
`endif
);

  localparam int unsigned    CNT_W      = $clog2(FLUSH_DEPTH + 1);
  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_DEPTH - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_d;
  logic              redirect_d, flush_d;
  logic              eff_n, eff_z, eff_v, eff_c;
  logic              cond_taken_c, br_taken_c;
  br_type_t          br_kind;

  // Forwarding: a flag-setting op in EX overrides the architectural flags.
  always_comb begin
    eff_n = ex_set_flags ? alu_negative : curr_negative;
    eff_z = ex_set_flags ? alu_zero     : curr_zero;
    eff_v = ex_set_flags ? alu_overflow : curr_overflow;
    eff_c = ex_set_flags ? alu_carryout : curr_carryout;
  end

  cond_eval u_cond_eval (
    .cond    (cond),
    .n       (eff_n),
    .z       (eff_z),
    .v       (eff_v),
    .c       (eff_c),
    .taken_c (cond_taken_c)
  );

  // Taken decision per branch kind.
  always_comb begin
    br_kind    = br_type_t'(br_type);
    br_taken_c = 1'b0;
    case (br_kind)
      BR_UNCOND: br_taken_c = 1'b1;
      BR_COND:   br_taken_c = cond_taken_c;
      BR_CBZ:    br_taken_c = reg_is_zero;
      BR_CBNZ:   br_taken_c = !reg_is_zero;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      flush       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      redirect    <= redirect_d;
      redirect_pc <= pc_d;
      flush       <= flush_d;
      busy        <= flush_d;
    end
  end

  // Next state; outputs are computed for the upcoming cycle so they register cleanly.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    redirect_d = 1'b0;
    pc_d       = redirect_pc;
    case (state_q)
      S_IDLE: begin
        if (br_valid && br_taken_c) begin
          state_d    = S_REDIRECT;
          redirect_d = 1'b1;
          pc_d       = br_target;
        end
      end
      S_REDIRECT: begin
        cnt_d   = FLUSH_INIT;
        state_d = (FLUSH_INIT != '0) ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    flush_d = (state_d != S_IDLE);
  end

`ifdef BRANCH_STATS_EN
  // Saturating outcome counters for branches accepted in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      taken_count    <= '0;
      nottaken_count <= '0;
    end else if (state_q == S_IDLE && br_valid) begin
      if (br_taken_c) begin
        if (taken_count != '1) taken_count <= taken_count + STAT_W'(1);
      end else begin
        if (nottaken_count != '1) nottaken_count <= nottaken_count + STAT_W'(1);
      end
    end
  end
`endif

endmodule
